el2_exu_div_transmitter: RTL and testbench
==========================================

Name: el2_exu_div_transmitter

Overview:
Transmit side of the divider NoC link. Accepts one divide request (operands plus control) from the EXU issue side with a valid/ready handshake and packs it into a fixed packet. It serializes the packet into flits for the node_port.up flit channel. It is the counterpart of the divider result receiver: same serial framing (LSB-first flits, zero padding, last-flit marker) and same flush semantics.

Parameters:
PACKET_BITS, 66, packed request width: divisor[31:0], dividend[63:32], div_signed[64], div_rem[65].
FLIT_BITS, 32, payload width of one flit.
NUM_FLITS, ceil(PACKET_BITS/FLIT_BITS) = 3, derived localparam and not overridable; packet padded to NUM_FLITS*FLIT_BITS with zeros in the MSBs.

Ports:
clk  input  1  NoC clock (clk_noc at instantiation); all state on rising edge.
rst  input  1  synchronous, active-high reset (driven with ~rst_l at instantiation).
in_valid  input  1  divide request valid.
in_ready  output  1  request accepted when in_valid && in_ready.
dividend  input  32  operand A.
divisor  input  32  operand B.
div_signed  input  1  signed divide.
div_rem  input  1  return remainder instead of quotient.
flush  input  1  pipeline flush from EXU.
flit_valid  output  1  flit present, maps to node_port.up valid.
flit_ready  input  1  downstream accepts flit, maps to node_port.up ready.
flit_data  output  FLIT_BITS  flit payload.
flit_last  output  1  marks final flit of packet.
busy  output  1  packet in flight (state SEND).
sent  output  1  one-cycle pulse when the final flit of a non-cancelled packet handshakes.

Behaviour:
- Reset values: state IDLE, flit_valid=0, flit_data=0, flit_last=0, busy=0, sent=0, flit counter=0, cancel flag=0. in_ready=1 after reset. Reset mid-packet abandons the packet immediately; no further flits are emitted.
- Storage: shift register of NUM_FLITS*FLIT_BITS bits; 2-bit flit index cnt (0..NUM_FLITS-1); 1-bit cancel flag.
- Outputs flit_data, flit_valid, flit_last are registered. flit_data = shreg[FLIT_BITS-1:0]. flit_last = (cnt == NUM_FLITS-1).
- Flit handshake: a flit transfers on a cycle with flit_valid && flit_ready. flit_valid and flit_data stay stable while flit_ready=0 (no retraction, no data change).
- IDLE:
  - in_ready=1, flit_valid=0.
  - On accept: shreg <= zero-padded {div_rem, div_signed, dividend, divisor}, cnt<=0, cancel<=0, go to SEND.
  - First flit_valid appears the next cycle (latency 1).
- SEND:
  - On each flit handshake with cnt < NUM_FLITS-1: shreg shifts right by FLIT_BITS (zero fill) and cnt increments.
  - On handshake with cnt == NUM_FLITS-1: packet done and sent pulses next cycle unless cancel=1.
  - If in_valid is also high that cycle, the new request loads (in_ready=1 only on this exact cycle), cnt<=0, and the state stays SEND. This gives back-to-back packets with no bubble. Otherwise go to IDLE.
  - in_ready = (state==IDLE) || (flit_valid && flit_ready && flit_last).
- Flush:
  - In IDLE: no effect, and a request presented in the same cycle is still accepted.
  - In SEND: the packet is NOT truncated, so the receiver framing stays intact. All remaining flits are sent, cancel<=1, and sent is suppressed for that packet.
  - Flush on the same cycle as a last-flit handshake plus new accept: flush applies to the completing packet only; the new packet has cancel=0.
- busy = (state==SEND).
- No combinational path from flit_ready to flit_data or flit_valid. in_ready depends combinationally on flit_ready, which is required for the zero-bubble reload.

Test Plan:
1. After reset: dividend=32'h0000_0064, divisor=32'h0000_0007, div_signed=1, div_rem=0, flit_ready=1 -> flits 32'h7, 32'h64, 32'h1 on 3 consecutive cycles starting 1 cycle after accept; flit_last only on the 3rd; sent pulses once.
2. Same request with flit_ready held 0 for 5 cycles at flit 1 -> flit_data stays 32'h64 and flit_valid stays 1 throughout; completes after release; in_ready=0 during stall.
3. Two requests back-to-back, flit_ready=1, second with div_rem=1 -> 6 contiguous flits with no idle cycle; 6th flit = 32'h2; two sent pulses.
4. flush asserted during flit 1 -> all 3 flits still sent with unchanged data; sent stays 0; next packet sends and pulses sent normally.
5. rst asserted during flit 2 -> next cycle flit_valid=0, busy=0, in_ready=1; new request restarts at flit 0.
6. Random operands plus random flit_ready (50%) for 1000 packets -> scoreboard reassembles the 66-bit packets LSB-first, padding bits are all zero, and every flit_last count equals the packet count.

Source files
------------

// File: rtl/el2_exu_div_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : el2_exu_div_transmitter_if
// Description : Signal bundle for the divider NoC transmit link. It carries
//               two groups of signals:
//               - request side: in_valid/in_ready, dividend, divisor,
//                 div_signed, div_rem and flush, coming from the EXU issue
//                 logic;
//               - flit side: flit_valid/flit_ready, flit_data and flit_last,
//                 going to node_port.up, plus the busy and sent status.
//               master : environment view. It drives requests and consumes
//                        flits.
//               slave  : transmitter view. It accepts requests and produces
//                        flits.
// Revision    : 1.0 - initial release
// ============================================================================
interface el2_exu_div_transmitter_if #(
  parameter int FLIT_BITS = 32
);
  // request side
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          dividend;
  logic [31:0]          divisor;
  logic                 div_signed;
  logic                 div_rem;
  logic                 flush;
  // flit side (node_port.up)
  logic                 flit_valid;
  logic                 flit_ready;
  logic [FLIT_BITS-1:0] flit_data;
  logic                 flit_last;
  // status
  logic                 busy;
  logic                 sent;

  modport master (
    output in_valid, dividend, divisor, div_signed, div_rem, flush, flit_ready,
    input  in_ready, flit_valid, flit_data, flit_last, busy, sent
  );

  modport slave (
    input  in_valid, dividend, divisor, div_signed, div_rem, flush, flit_ready,
    output in_ready, flit_valid, flit_data, flit_last, busy, sent
  );
endinterface
`default_nettype wire

// File: rtl/el2_exu_div_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : el2_exu_div_transmitter
// Description : Transmit side of the divider NoC link. The module accepts
//               one divide request with a valid/ready handshake and packs it
//               as {div_rem, div_signed, dividend, divisor}. It zero-pads the
//               packet to NUM_FLITS*FLIT_BITS bits and sends it LSB-first as
//               flits, marking the final flit with flit_last.
//
//               A flush does not truncate a packet that is in flight, so the
//               receiver framing stays intact. The flush only sets a cancel
//               flag, and that flag suppresses the sent pulse.
//
//               A new request can load in the same cycle as the last-flit
//               handshake, so consecutive packets have no bubble between
//               them.
// Ports       : clk    - NoC clock; all state changes on the rising edge
//               rst    - synchronous, active-high reset
//               bus    - el2_exu_div_transmitter_if.slave. It carries the
//                        request handshake, the operands and flush, the flit
//                        channel, and the busy/sent status.
// Revision    : 1.0 - initial release
// ============================================================================
module el2_exu_div_transmitter #(
  parameter int PACKET_BITS = 66,
  parameter int FLIT_BITS   = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  el2_exu_div_transmitter_if.slave   bus
);

  // Derived framing constants.
  localparam int c_NUM_FLITS  = (PACKET_BITS + FLIT_BITS - 1) / FLIT_BITS;
  localparam int c_SHREG_BITS = c_NUM_FLITS * FLIT_BITS;
  localparam int c_CNT_BITS   = (c_NUM_FLITS > 1) ? $clog2(c_NUM_FLITS) : 1;

  localparam logic [c_CNT_BITS-1:0] c_LAST_CNT      = c_CNT_BITS'(c_NUM_FLITS - 1);
  localparam logic                  c_FIRST_IS_LAST = (c_NUM_FLITS == 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                  r_state;
  logic [c_SHREG_BITS-1:0] r_shreg;
  logic [c_CNT_BITS-1:0]   r_cnt;
  logic                    r_cancel;
  logic                    r_flit_valid;
  logic                    r_flit_last;
  logic                    r_sent;

  logic                    w_flit_hs;
  logic                    w_last_hs;
  logic                    w_in_ready;
  logic                    w_accept;
  logic [PACKET_BITS-1:0]  w_packet;
  logic [c_SHREG_BITS-1:0] w_load;
  logic [c_CNT_BITS-1:0]   w_cnt_next;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign w_flit_hs = r_flit_valid && bus.flit_ready;
  assign w_last_hs = w_flit_hs && r_flit_last;

  // in_ready opens on the last-flit handshake so that the next packet can
  // load with no bubble. This makes in_ready depend on flit_ready
  // combinationally. flit_valid and flit_data come from registers only.
  assign w_in_ready = (r_state == ST_IDLE) || w_last_hs;
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_cnt_next = r_cnt + 1'b1;

  // Packed request. The upper bits of the shift register are zero padding.
  assign w_packet = PACKET_BITS'({bus.div_rem, bus.div_signed, bus.dividend, bus.divisor});

  always_comb begin
    w_load                  = '0;
    w_load[PACKET_BITS-1:0] = w_packet;
  end

  // --------------------------------------------------------------------------
  // Control and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset abandons any packet in flight immediately.
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_cancel     <= 1'b0;
      r_flit_valid <= 1'b0;
      r_flit_last  <= 1'b0;
      r_sent       <= 1'b0;
    end else begin
      r_sent <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // A flush has no effect in IDLE, and a request presented in the
          // same cycle as the flush is still accepted.
          if (w_accept) begin
            r_state      <= ST_SEND;
            r_shreg      <= w_load;
            r_cnt        <= '0;
            r_cancel     <= 1'b0;
            r_flit_valid <= 1'b1;
            r_flit_last  <= c_FIRST_IS_LAST;
          end
        end

        ST_SEND: begin
          // A flush marks the packet in flight as cancelled. All of its
          // flits are still sent. The assignment to r_cancel in the reload
          // path below overrides this one, so a flush never carries over
          // into a newly loaded packet.
          if (bus.flush) begin
            r_cancel <= 1'b1;
          end

          if (w_last_hs) begin
            // A flush in this same cycle cancels the completing packet.
            r_sent <= ~(r_cancel | bus.flush);
            if (bus.in_valid) begin
              r_shreg      <= w_load;
              r_cnt        <= '0;
              r_cancel     <= 1'b0;
              r_flit_valid <= 1'b1;
              r_flit_last  <= c_FIRST_IS_LAST;
            end else begin
              r_state      <= ST_IDLE;
              r_shreg      <= '0;
              r_cnt        <= '0;
              r_cancel     <= 1'b0;
              r_flit_valid <= 1'b0;
              r_flit_last  <= 1'b0;
            end
          end else if (w_flit_hs) begin
            r_shreg     <= r_shreg >> FLIT_BITS;
            r_cnt       <= w_cnt_next;
            r_flit_last <= (w_cnt_next == c_LAST_CNT);
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_flit_valid <= 1'b0;
          r_flit_last  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready   = w_in_ready;
  assign bus.flit_valid = r_flit_valid;
  assign bus.flit_data  = r_shreg[FLIT_BITS-1:0];
  assign bus.flit_last  = r_flit_last;
  assign bus.busy       = (r_state == ST_SEND);
  assign bus.sent       = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_el2_exu_div_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_el2_exu_div_transmitter
// Description : Self-checking bench for el2_exu_div_transmitter. The tests
//               cover reset, a single packet, a stall, back-to-back packets,
//               flush cases, reset in the middle of a packet, and a random
//               scoreboard run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_el2_exu_div_transmitter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   sent_cnt;

  el2_exu_div_transmitter_if #(.FLIT_BITS(32)) bus ();

  el2_exu_div_transmitter #(
    .PACKET_BITS (66),
    .FLIT_BITS   (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts the registered sent pulses. It samples the value from before the
  // edge.
  always @(posedge clk) begin
    if (bus.sent === 1'b1) sent_cnt++;
  end

  // Move to the drive point, 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r);
    bus.in_valid   = 1'b1;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_signed = s;
    bus.div_rem    = r;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.flit_ready = 1'b1;
    bus.dividend = '0; bus.divisor = '0; bus.div_signed = 1'b0; bus.div_rem = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    checks++; if (bus.flit_valid !== 1'b0) begin failures++; $display("FAIL rst_flit_valid got=%0h exp=0", bus.flit_valid); end
    checks++; if (bus.flit_data !== 32'h0) begin failures++; $display("FAIL rst_flit_data got=%0h exp=0", bus.flit_data); end
    checks++; if (bus.flit_last !== 1'b0) begin failures++; $display("FAIL rst_flit_last got=%0h exp=0", bus.flit_last); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
    checks++; if (bus.sent !== 1'b0) begin failures++; $display("FAIL rst_sent got=%0h exp=0", bus.sent); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", bus.in_ready); end
    cyc();
    sent_cnt = 0;
  endtask

  task automatic test_basic();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h7; exp_data[1] = 32'h64; exp_data[2] = 32'h1;
    sent_cnt = 0;
    bus.flit_ready = 1'b1;
    set_req(32'h64, 32'h7, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready_idle got=%0h exp=1", bus.in_ready); end
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.flit_valid !== 1'b1) begin failures++; $display("FAIL basic_valid[%0d] got=%0h exp=1", i, bus.flit_valid); end
      checks++; if (bus.flit_data !== exp_data[i]) begin failures++; $display("FAIL basic_data[%0d] got=%0h exp=%0h", i, bus.flit_data, exp_data[i]); end
      checks++; if (bus.flit_last !== (i == 2)) begin failures++; $display("FAIL basic_last[%0d] got=%0h exp=%0h", i, bus.flit_last, (i == 2)); end
      checks++; if (bus.in_ready !== (i == 2)) begin failures++; $display("FAIL basic_in_ready[%0d] got=%0h exp=%0h", i, bus.in_ready, (i == 2)); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy[%0d] got=%0h exp=1", i, bus.busy); end
      cyc();
    end
    @(negedge clk);
    checks++; if (bus.flit_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_after got=%0h exp=0", bus.flit_valid); end
    checks++; if (bus.sent !== 1'b1) begin failures++; $display("FAIL basic_sent_pulse got=%0h exp=1", bus.sent); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%0h exp=0", bus.busy); end
    cyc();
    @(negedge clk);
    checks++; if (bus.sent !== 1'b0) begin failures++; $display("FAIL basic_sent_one_cycle got=%0h exp=0", bus.sent); end
    cyc();
    checks++; if (sent_cnt !== 1) begin failures++; $display("FAIL basic_sent_count got=%0d exp=1", sent_cnt); end
  endtask

  task automatic test_stall();
    sent_cnt = 0;
    bus.flit_ready = 1'b1;
    set_req(32'h64, 32'h7, 1'b1, 1'b0);
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.flit_data !== 32'h7) begin failures++; $display("FAIL stall_flit0 got=%0h exp=7", bus.flit_data); end
    cyc();
    bus.flit_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.flit_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%0h exp=1", i, bus.flit_valid); end
      checks++; if (bus.flit_data !== 32'h64) begin failures++; $display("FAIL stall_data[%0d] got=%0h exp=64", i, bus.flit_data); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%0h exp=0", i, bus.in_ready); end
      cyc();
    end
    bus.flit_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.flit_data !== 32'h64) begin failures++; $display("FAIL stall_release got=%0h exp=64", bus.flit_data); end
    cyc();
    @(negedge clk);
    checks++; if (bus.flit_data !== 32'h1 || bus.flit_last !== 1'b1) begin failures++; $display("FAIL stall_flit2 got=%0h/%0h exp=1/1", bus.flit_data, bus.flit_last); end
    cyc(); cyc(); cyc();
    checks++; if (sent_cnt !== 1) begin failures++; $display("FAIL stall_sent_count got=%0d exp=1", sent_cnt); end
  endtask

  // Sends two packets back to back. If with_flush is set, flush is high in
  // the cycle of the first packet's last-flit handshake.
  task automatic run_b2b(input bit with_flush);
    logic [31:0] exp_data [6];
    exp_data[0] = 32'h7; exp_data[1] = 32'h64; exp_data[2] = 32'h1;
    exp_data[3] = 32'h7; exp_data[4] = 32'h64; exp_data[5] = 32'h2;
    bus.flit_ready = 1'b1;
    set_req(32'h64, 32'h7, 1'b1, 1'b0);
    cyc();
    set_req(32'h64, 32'h7, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (with_flush && i == 2) bus.flush = 1'b1;
      @(negedge clk);
      checks++; if (bus.flit_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0h exp=1", i, bus.flit_valid); end
      checks++; if (bus.flit_data !== exp_data[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%0h exp=%0h", i, bus.flit_data, exp_data[i]); end
      checks++; if (bus.flit_last !== (i % 3 == 2)) begin failures++; $display("FAIL b2b_last[%0d] got=%0h exp=%0h", i, bus.flit_last, (i % 3 == 2)); end
      if (i == 2) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_last got=%0h exp=1", bus.in_ready); end
      end
      cyc();
      if (i == 2) begin
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (bus.flit_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%0h exp=0", bus.flit_valid); end
    cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    sent_cnt = 0;
    run_b2b(1'b0);
    checks++; if (sent_cnt !== 2) begin failures++; $display("FAIL b2b_sent_count got=%0d exp=2", sent_cnt); end
  endtask

  task automatic test_flush();
    logic [31:0] exp_data [3];
    // A flush during flit 1: every flit is still sent, and sent is
    // suppressed.
    sent_cnt = 0;
    bus.flit_ready = 1'b1;
    set_req(32'h64, 32'h7, 1'b1, 1'b0);
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.flit_data !== 32'h7) begin failures++; $display("FAIL flush_flit0 got=%0h exp=7", bus.flit_data); end
    cyc();
    bus.flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.flit_data !== 32'h64 || bus.flit_valid !== 1'b1) begin failures++; $display("FAIL flush_flit1 got=%0h/%0h exp=64/1", bus.flit_data, bus.flit_valid); end
    cyc();
    bus.flush = 1'b0;
    @(negedge clk);
    checks++; if (bus.flit_data !== 32'h1 || bus.flit_last !== 1'b1) begin failures++; $display("FAIL flush_flit2 got=%0h/%0h exp=1/1", bus.flit_data, bus.flit_last); end
    cyc(); cyc(); cyc();
    checks++; if (sent_cnt !== 0) begin failures++; $display("FAIL flush_sent_suppressed got=%0d exp=0", sent_cnt); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL flush_busy_after got=%0h exp=0", bus.busy); end

    // A flush in IDLE together with a request: the request is accepted, and
    // the packet pulses sent normally.
    sent_cnt = 0;
    exp_data[0] = 32'h7; exp_data[1] = 32'h64; exp_data[2] = 32'h3;
    set_req(32'h64, 32'h7, 1'b1, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_in_ready got=%0h exp=1", bus.in_ready); end
    cyc();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.flit_valid !== 1'b1 || bus.flit_data !== exp_data[i]) begin failures++; $display("FAIL flush_idle_data[%0d] got=%0h/%0h exp=1/%0h", i, bus.flit_valid, bus.flit_data, exp_data[i]); end
      cyc();
    end
    cyc(); cyc();
    checks++; if (sent_cnt !== 1) begin failures++; $display("FAIL flush_idle_sent got=%0d exp=1", sent_cnt); end

    // A flush on the last-flit handshake with a reload: only the completing
    // packet is cancelled.
    sent_cnt = 0;
    run_b2b(1'b1);
    checks++; if (sent_cnt !== 1) begin failures++; $display("FAIL flush_last_reload_sent got=%0d exp=1", sent_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h7; exp_data[1] = 32'h64; exp_data[2] = 32'h1;
    bus.flit_ready = 1'b1;
    set_req(32'h64, 32'h7, 1'b1, 1'b0);
    cyc();
    bus.in_valid = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    checks++; if (bus.flit_data !== 32'h1 || bus.flit_valid !== 1'b1) begin failures++; $display("FAIL rstmid_flit2 got=%0h/%0h exp=1/1", bus.flit_data, bus.flit_valid); end
    sent_cnt = 0;
    rst = 1'b1;
    cyc();
    @(negedge clk);
    checks++; if (bus.flit_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0h exp=0", bus.flit_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0h exp=0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%0h exp=1", bus.in_ready); end
    checks++; if (bus.sent !== 1'b0) begin failures++; $display("FAIL rstmid_sent got=%0h exp=0", bus.sent); end
    cyc();
    rst = 1'b0;
    sent_cnt = 0;
    set_req(32'h64, 32'h7, 1'b1, 1'b0);
    cyc();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.flit_valid !== 1'b1 || bus.flit_data !== exp_data[i]) begin failures++; $display("FAIL rstmid_restart[%0d] got=%0h/%0h exp=1/%0h", i, bus.flit_valid, bus.flit_data, exp_data[i]); end
      cyc();
    end
    cyc(); cyc();
    checks++; if (sent_cnt !== 1) begin failures++; $display("FAIL rstmid_sent_count got=%0d exp=1", sent_cnt); end
  endtask

  task automatic test_random();
    logic [65:0] expq [$];
    logic [65:0] exp_pkt;
    logic [95:0] asm_pkt;
    logic [31:0] prev_data;
    int          idx;
    int          pkts_acc;
    int          pkts_done;
    int          lasts;
    int          idle_cycles;
    bit          stalled;
    bit          acc_now;
    idx = 0; pkts_acc = 0; pkts_done = 0; lasts = 0; stalled = 1'b0; asm_pkt = '0;
    idle_cycles = 0; prev_data = '0;
    sent_cnt = 0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 40000 && pkts_done < 1000; c++) begin
      bus.flit_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid && pkts_acc < 1000 && $urandom_range(0, 3) != 0)
        set_req($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      acc_now = 1'b0;
      if (stalled) begin
        checks++; if (bus.flit_valid !== 1'b1 || bus.flit_data !== prev_data) begin failures++; $display("FAIL rand_stall_stable got=%0h/%0h exp=1/%0h", bus.flit_valid, bus.flit_data, prev_data); end
      end
      stalled   = bus.flit_valid && !bus.flit_ready;
      prev_data = bus.flit_data;
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back({bus.div_rem, bus.div_signed, bus.dividend, bus.divisor});
        pkts_acc++;
        acc_now = 1'b1;
      end
      if (bus.flit_valid && bus.flit_ready) begin
        if (idx < 3) asm_pkt[idx*32 +: 32] = bus.flit_data;
        checks++; if (bus.flit_last !== (idx == 2)) begin failures++; $display("FAIL rand_last_pos idx=%0d got=%0h exp=%0h", idx, bus.flit_last, (idx == 2)); end
        if (bus.flit_last) begin
          lasts++;
          exp_pkt = (expq.size() > 0) ? expq.pop_front() : 66'h0;
          checks++; if (asm_pkt !== {30'h0, exp_pkt}) begin failures++; $display("FAIL rand_packet[%0d] got=%024h exp=%024h", pkts_done, asm_pkt, {30'h0, exp_pkt}); end
          pkts_done++;
          idx = 0;
          asm_pkt = '0;
        end else begin
          idx++;
        end
      end
      @(posedge clk);
      #1;
      if (acc_now) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.flit_ready = 1'b1;
    while (bus.busy === 1'b1 && idle_cycles < 20) begin cyc(); idle_cycles++; end
    cyc(); cyc();
    checks++; if (pkts_done !== 1000) begin failures++; $display("FAIL rand_packets_done got=%0d exp=1000", pkts_done); end
    checks++; if (lasts !== pkts_acc) begin failures++; $display("FAIL rand_last_count got=%0d exp=%0d", lasts, pkts_acc); end
    checks++; if (sent_cnt !== pkts_acc) begin failures++; $display("FAIL rand_sent_count got=%0d exp=%0d", sent_cnt, pkts_acc); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sent_cnt = 0;
    rst      = 1'b1;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.flit_ready = 1'b0;
    bus.dividend = '0; bus.divisor = '0; bus.div_signed = 1'b0; bus.div_rem = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
